// File: rtl/chip_select_decoder.sv
// Registered chip-select decoder: a single-cycle request on the top SEL_W address bits
// drives one one-hot enable for WAIT+1 cycles followed by ack, or a one-cycle err for unpopulated regions.
module chip_select_decoder #(
    parameter int SEL_W  = 2,
    parameter int ADDR_W = 32,
    parameter int WAIT   = 2,
    parameter logic [(1<<SEL_W)-1:0] MAP_MASK = '1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req,
    input  logic [ADDR_W-1:0]       addr,
    output logic [(1<<SEL_W)-1:0]   ce,
    output logic                    ack,
    output logic                    err,
    output logic                    busy
);

    localparam int NUM_CH = 1 << SEL_W;
    localparam int CNT_W  = (WAIT < 1) ? 1 : $clog2(WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_C = CNT_W'(WAIT);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, ACTIVE, ERR} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_CH-1:0]   ce_q, ce_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic [SEL_W-1:0]    region;

    assign region = addr[ADDR_W-1 -: SEL_W];

    generate
        if (ADDR_W > SEL_W) begin : g_low_addr
            logic unused_low_addr;
            assign unused_low_addr = ^addr[ADDR_W-SEL_W-1:0];
        end
    endgenerate

    // ack is registered, so it is raised on the edge that enters the last ce cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ce_d    = ce_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                ce_d = '0;
                if (req) begin
                    if (MAP_MASK[region]) begin
                        state_d = ACTIVE;
                        cnt_d   = WAIT_C;
                        ce_d    = NUM_CH'(1) << region;
                        ack_d   = (WAIT_C == '0);
                    end else begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    ce_d    = '0;
                end else begin
                    cnt_d = cnt_q - ONE_C;
                    ack_d = (cnt_q == ONE_C);
                end
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                ce_d    = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ce_q    <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ce_q    <= ce_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign ce   = ce_q;
    assign ack  = ack_q;
    assign err  = err_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_chip_select_decoder.sv
// Bench for chip_select_decoder: two configurations (WAIT=2/mask 1011 and WAIT=0/mask F)
// share stimulus and are compared every cycle against an access-timeline reference model.
module tb_chip_select_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic [31:0] addr = '0;
    logic [3:0]  ce_a, ce_b;
    logic        ack_a, err_a, busy_a;
    logic        ack_b, err_b, busy_b;

    chip_select_decoder #(.SEL_W(2), .ADDR_W(32), .WAIT(2), .MAP_MASK(4'b1011)) dut_a (
        .clk(clk), .rst(rst), .req(req), .addr(addr),
        .ce(ce_a), .ack(ack_a), .err(err_a), .busy(busy_a)
    );

    chip_select_decoder #(.SEL_W(2), .ADDR_W(32), .WAIT(0), .MAP_MASK(4'hF)) dut_b (
        .clk(clk), .rst(rst), .req(req), .addr(addr),
        .ce(ce_b), .ack(ack_b), .err(err_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: each accepted access occupies the cycle interval [start, end].
    int          cfg_wait[2] = '{2, 0};
    logic [3:0]  cfg_map[2]  = '{4'b1011, 4'hF};
    int          cyc = 0;
    int          acc_start[2] = '{0, 0};
    int          acc_end[2]   = '{-10, -10};
    int          acc_reg[2]   = '{0, 0};
    bit          acc_err[2]   = '{1'b0, 1'b0};

    function automatic logic [6:0] expected(int i);
        logic [3:0] onehot;
        if (rst) return 7'd0;
        if (cyc >= acc_start[i] && cyc <= acc_end[i]) begin
            if (acc_err[i]) return 7'b0000_011;
            onehot = 4'(1 << acc_reg[i]);
            return {onehot, (cyc == acc_end[i]), 1'b0, 1'b1};
        end
        return 7'd0;
    endfunction

    task automatic model_edge();
        int r;
        cyc++;
        if (rst) begin
            acc_end = '{-10, -10};
            return;
        end
        for (int i = 0; i < 2; i++) begin
            if (req === 1'b1 && (cyc - 1) > acc_end[i]) begin
                r = int'(addr[31:30]);
                acc_start[i] = cyc;
                acc_reg[i]   = r;
                if (cfg_map[i][r]) begin
                    acc_err[i] = 1'b0;
                    acc_end[i] = cyc + cfg_wait[i];
                end else begin
                    acc_err[i] = 1'b1;
                    acc_end[i] = cyc;
                end
            end
        end
    endtask

    task automatic check(string name);
        logic [6:0] act[2];
        logic [6:0] exp_v;
        act[0] = {ce_a, ack_a, err_a, busy_a};
        act[1] = {ce_b, ack_b, err_b, busy_b};
        for (int i = 0; i < 2; i++) begin
            exp_v = expected(i);
            checks++;
            if (act[i] !== exp_v) begin
                errors++;
                $display("FAIL %s dut%0d cyc=%0d: got ce=%b ack=%b err=%b busy=%b, want ce=%b ack=%b err=%b busy=%b",
                         name, i, cyc, act[i][6:3], act[i][2], act[i][1], act[i][0],
                         exp_v[6:3], exp_v[2], exp_v[1], exp_v[0]);
            end
        end
    endtask

    task automatic step(input logic r, input logic [31:0] a, input string name);
        req  = r;
        addr = a;
        @(posedge clk);
        model_edge();
        #1;
        check(name);
    endtask

    task automatic pulse_reset(input int n);
        #2 rst = 1'b1;
        acc_end = '{-10, -10};
        #1 check("rst_async");
        repeat (n) step(1'($urandom), $urandom, "rst_hold");
        rst = 1'b0;
        check("rst_release");
    endtask

    typedef struct {
        logic        r;
        logic [31:0] a;
        logic [3:0]  ce;
        logic        ack;
        logic        err;
        logic        busy;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int acks;
        int ce_cycles;
        int k;
        logic [31:0] b2b_addr;

        tbl[0] = '{1'b1, 32'hC000_1234, 4'b1000, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{1'b0, 32'h0000_0000, 4'b1000, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 32'h0000_0000, 4'b1000, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 32'h0000_0000, 4'b0000, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 32'h8000_0000, 4'b0000, 1'b0, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 32'h8000_0000, 4'b0000, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 32'h4000_0000, 4'b0010, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 32'h8000_0000, 4'b0010, 1'b0, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 32'h8000_0000, 4'b0010, 1'b1, 1'b0, 1'b1};
        tbl[9] = '{1'b1, 32'h8000_0000, 4'b0000, 1'b0, 1'b0, 1'b0};

        // Reset with random inputs: outputs must be zero immediately and throughout.
        #1 rst = 1'b1;
        #1 check("reset_imm");
        repeat (3) step(1'($urandom), $urandom, "reset_hold");
        rst = 1'b0;
        check("reset_release");

        // Table: mapped access, unmapped access, requests ignored while active.
        for (int i = 0; i < 10; i++) begin
            req  = tbl[i].r;
            addr = tbl[i].a;
            @(posedge clk);
            model_edge();
            #1;
            check("table_model");
            checks++;
            if ({ce_a, ack_a, err_a, busy_a} !== {tbl[i].ce, tbl[i].ack, tbl[i].err, tbl[i].busy}) begin
                errors++;
                $display("FAIL table[%0d]: got ce=%b ack=%b err=%b busy=%b, want ce=%b ack=%b err=%b busy=%b",
                         i, ce_a, ack_a, err_a, busy_a, tbl[i].ce, tbl[i].ack, tbl[i].err, tbl[i].busy);
            end
        end

        // Back-to-back with req held high; addr perturbed mid-run.
        step(1'b0, 32'h0, "b2b_idle");
        step(1'b0, 32'h0, "b2b_idle");
        acks = 0;
        ce_cycles = 0;
        for (int i = 0; i < 12; i++) begin
            b2b_addr = (i == 1 || i == 5) ? 32'h4000_0000 : 32'h0000_0010;
            step(1'b1, b2b_addr, "b2b");
            if (ack_a === 1'b1) acks++;
            if (ce_a === 4'b0001) ce_cycles++;
        end
        checks++;
        if (acks != 3 || ce_cycles != 9) begin
            errors++;
            $display("FAIL b2b_runs: got acks=%0d ce_cycles=%0d, want acks=3 ce_cycles=9", acks, ce_cycles);
        end

        // Reset in the second ACTIVE cycle, then a fresh access.
        step(1'b0, 32'h0, "mid_idle");
        step(1'b0, 32'h0, "mid_idle");
        step(1'b1, 32'hC000_1234, "mid_start");
        step(1'b0, 32'h0, "mid_second");
        pulse_reset(1);
        repeat (4) step(1'b0, 32'h0, "mid_after");
        step(1'b1, 32'h4000_0000, "mid_fresh");
        checks++;
        if (ce_a !== 4'b0010) begin
            errors++;
            $display("FAIL mid_fresh_ce: got ce=%b, want 0010", ce_a);
        end
        repeat (4) step(1'b0, 32'h0, "mid_tail");

        // WAIT=0 instance: ce and ack together for one cycle; X request in IDLE.
        step(1'b1, 32'h8000_0000, "w0_acc");
        checks++;
        if (ce_b !== 4'b0100 || ack_b !== 1'b1) begin
            errors++;
            $display("FAIL w0_acc: got ce=%b ack=%b, want ce=0100 ack=1", ce_b, ack_b);
        end
        step(1'b0, 32'h8000_0000, "w0_done");
        checks++;
        if (ce_b !== 4'b0000 || ack_b !== 1'b0) begin
            errors++;
            $display("FAIL w0_done: got ce=%b ack=%b, want ce=0000 ack=0", ce_b, ack_b);
        end
        repeat (3) step(1'b0, 32'h0, "x_idle");
        step(1'bx, 32'h8000_0000, "x_req");
        step(1'b0, 32'h0, "x_after");

        // Random traffic with occasional X requests and asynchronous resets.
        for (int i = 0; i < 400; i++) begin
            k = int'($urandom % 8);
            step((k < 3) ? 1'b1 : ((k < 7) ? 1'b0 : 1'bx), $urandom, "random");
            if ($urandom % 50 == 0) pulse_reset(1 + int'($urandom % 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
